// File: rtl/reorder_buffer.sv
`timescale 1ns/1ps
// reorder_buffer
//   Circular reorder buffer for the Tomasulo core. Allocates one entry per
//   dispatched instruction, answers two operand queries, captures CDB
//   results, retires in order to the regfile, hands stores to the LSB and
//   redirects the front end on branch mispredict or JALR.
//
//   Tags run 1..2^ROB_WIDTH-1; tag 0 means "no producer" and entry 0 is
//   never allocated.
//
//   Opcode classes recognised at retire (everything else is a plain
//   register-writing instruction such as ALU, load, LUI, AUIPC, JAL):
//     OP_JALR            4
//     OP_BEQ..OP_BGEU    5..10
//     OP_SB..OP_SW       16..18
//
//   Ports
//     clk_in, rst_in (async active-low), rdy_in (global enable)
//     dispatch_*_in      allocation request at tail
//     b_out, full_out    tag of next allocation, no free entry
//     rs/rt_h_in         query tags; rs/rt_ready_out, rs/rt_value_out answers
//     cdb_*_in           result broadcast
//     commit_*_out       registered regfile write, 1-cycle pulse
//     store_commit_out   held high while the head store is with the LSB
//     lsb_store_done_in  store finished
//     flush_out, flush_pc_out  registered redirect, 1-cycle pulse
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   S_RUN       | normal retire, one entry per cycle
//   S_STORE_WAIT| head store granted to LSB, waiting for done
module reorder_buffer #(
  parameter int ROB_WIDTH  = 4,
  parameter int ID_WIDTH   = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  dispatch_en_in,
  input  logic [OP_WIDTH-1:0]   dispatch_opcode_in,
  input  logic [REG_WIDTH-1:0]  dispatch_dest_in,
  input  logic [ADDR_WIDTH-1:0] dispatch_pc_in,
  input  logic                  dispatch_taken_in,
  output logic [ROB_WIDTH-1:0]  b_out,
  output logic                  full_out,
  input  logic [ROB_WIDTH-1:0]  rs_h_in,
  input  logic [ROB_WIDTH-1:0]  rt_h_in,
  output logic                  rs_ready_out,
  output logic                  rt_ready_out,
  output logic [ID_WIDTH-1:0]   rs_value_out,
  output logic [ID_WIDTH-1:0]   rt_value_out,
  input  logic                  cdb_en_in,
  input  logic [ROB_WIDTH-1:0]  cdb_tag_in,
  input  logic [ID_WIDTH-1:0]   cdb_value_in,
  input  logic                  cdb_taken_in,
  input  logic [ADDR_WIDTH-1:0] cdb_target_in,
  output logic                  commit_en_out,
  output logic [REG_WIDTH-1:0]  commit_reg_out,
  output logic [ID_WIDTH-1:0]   commit_value_out,
  output logic [ROB_WIDTH-1:0]  commit_tag_out,
  output logic                  store_commit_out,
  input  logic                  lsb_store_done_in,
  output logic                  flush_out,
  output logic [ADDR_WIDTH-1:0] flush_pc_out
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] LAST_TAG  = '1;
  localparam logic [ROB_WIDTH-1:0] FIRST_TAG = ROB_WIDTH'(1);

  localparam logic [OP_WIDTH-1:0] OP_JALR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_BGEU = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_SB   = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(18);

  typedef enum logic {S_RUN, S_STORE_WAIT} state_t;

  // Control state
  state_t                 state_q, state_d;
  logic [ROB_WIDTH-1:0]   head_q, head_d;
  logic [ROB_WIDTH-1:0]   tail_q, tail_d;
  logic [ROB_WIDTH-1:0]   count_q, count_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [DEPTH-1:0]       ready_q, ready_d;

  // Registered outputs
  logic                   commit_en_q, commit_en_d;
  logic [REG_WIDTH-1:0]   commit_reg_q, commit_reg_d;
  logic [ID_WIDTH-1:0]    commit_value_q, commit_value_d;
  logic [ROB_WIDTH-1:0]   commit_tag_q, commit_tag_d;
  logic                   store_commit_q, store_commit_d;
  logic                   flush_q, flush_d;
  logic [ADDR_WIDTH-1:0]  flush_pc_q, flush_pc_d;

  // Entry payload; only meaningful while the valid bit is set, so no reset
  logic [OP_WIDTH-1:0]    op_q     [DEPTH];
  logic [REG_WIDTH-1:0]   dest_q   [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_q     [DEPTH];
  logic                   pred_q   [DEPTH];
  logic                   act_q    [DEPTH];
  logic [ID_WIDTH-1:0]    value_q  [DEPTH];
  logic [ADDR_WIDTH-1:0]  target_q [DEPTH];

  logic full;
  logic active;
  logic disp_fire;
  logic cdb_fire;
  logic head_rdy;
  logic head_store;
  logic head_branch;
  logic head_jalr;
  logic run_commit;
  logic store_done;
  logic retire;

  function automatic logic [ROB_WIDTH-1:0] next_tag(input logic [ROB_WIDTH-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + ROB_WIDTH'(1);
  endfunction

  assign full   = (count_q == LAST_TAG);
  // The flush cycle discards all dispatch/CDB/commit activity.
  assign active = rdy_in & ~flush_q;

  assign disp_fire = active & dispatch_en_in & ~full;
  assign cdb_fire  = active & cdb_en_in & (cdb_tag_in != '0) & valid_q[cdb_tag_in];

  assign head_rdy    = valid_q[head_q] & ready_q[head_q];
  assign head_store  = (op_q[head_q] >= OP_SB)  && (op_q[head_q] <= OP_SW);
  assign head_branch = (op_q[head_q] >= OP_BEQ) && (op_q[head_q] <= OP_BGEU);
  assign head_jalr   = (op_q[head_q] == OP_JALR);

  // Ready is registered, so a CDB write to the head is only seen as
  // committable on the following cycle.
  assign run_commit = active & (state_q == S_RUN) & head_rdy;
  assign store_done = active & (state_q == S_STORE_WAIT) & lsb_store_done_in;
  assign retire     = (run_commit & ~head_store) | store_done;

  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    commit_en_d    = 1'b0;
    commit_reg_d   = commit_reg_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    store_commit_d = store_commit_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;

    if (!rdy_in) begin
      flush_d = flush_q;
    end else if (flush_q) begin
      state_d        = S_RUN;
      head_d         = FIRST_TAG;
      tail_d         = FIRST_TAG;
      count_d        = '0;
      valid_d        = '0;
      ready_d        = '0;
      store_commit_d = 1'b0;
    end else begin
      if (cdb_fire) begin
        ready_d[cdb_tag_in] = 1'b1;
      end
      if (disp_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = next_tag(tail_q);
      end

      if (run_commit) begin
        if (head_store) begin
          state_d        = S_STORE_WAIT;
          store_commit_d = 1'b1;
        end else begin
          commit_en_d    = ~head_branch & (dest_q[head_q] != '0);
          commit_reg_d   = dest_q[head_q];
          commit_value_d = value_q[head_q];
          commit_tag_d   = head_q;
          if (head_jalr) begin
            flush_d    = 1'b1;
            flush_pc_d = target_q[head_q];
          end else if (head_branch && (act_q[head_q] != pred_q[head_q])) begin
            flush_d    = 1'b1;
            flush_pc_d = act_q[head_q] ? target_q[head_q]
                                       : pc_q[head_q] + ADDR_WIDTH'(4);
          end
        end
      end

      if (store_done) begin
        state_d        = S_RUN;
        store_commit_d = 1'b0;
      end

      if (retire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = next_tag(head_q);
      end

      case ({disp_fire, retire})
        2'b10:   count_d = count_q + ROB_WIDTH'(1);
        2'b01:   count_d = count_q - ROB_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= S_RUN;
      head_q         <= FIRST_TAG;
      tail_q         <= FIRST_TAG;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_reg_q   <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      store_commit_q <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      commit_en_q    <= commit_en_d;
      commit_reg_q   <= commit_reg_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      store_commit_q <= store_commit_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (disp_fire) begin
      op_q[tail_q]   <= dispatch_opcode_in;
      dest_q[tail_q] <= dispatch_dest_in;
      pc_q[tail_q]   <= dispatch_pc_in;
      pred_q[tail_q] <= dispatch_taken_in;
    end
    if (cdb_fire) begin
      value_q[cdb_tag_in]  <= cdb_value_in;
      act_q[cdb_tag_in]    <= cdb_taken_in;
      target_q[cdb_tag_in] <= cdb_target_in;
    end
  end

  // Operand queries, with same-cycle CDB bypass; tag 0 is never ready.
  always_comb begin
    rs_ready_out = 1'b0;
    rs_value_out = '0;
    if (rs_h_in != '0) begin
      if (cdb_en_in && (cdb_tag_in == rs_h_in)) begin
        rs_ready_out = 1'b1;
        rs_value_out = cdb_value_in;
      end else if (valid_q[rs_h_in] && ready_q[rs_h_in]) begin
        rs_ready_out = 1'b1;
        rs_value_out = value_q[rs_h_in];
      end
    end
  end

  always_comb begin
    rt_ready_out = 1'b0;
    rt_value_out = '0;
    if (rt_h_in != '0) begin
      if (cdb_en_in && (cdb_tag_in == rt_h_in)) begin
        rt_ready_out = 1'b1;
        rt_value_out = cdb_value_in;
      end else if (valid_q[rt_h_in] && ready_q[rt_h_in]) begin
        rt_ready_out = 1'b1;
        rt_value_out = value_q[rt_h_in];
      end
    end
  end

  assign b_out            = tail_q;
  assign full_out         = full;
  assign commit_en_out    = commit_en_q;
  assign commit_reg_out   = commit_reg_q;
  assign commit_value_out = commit_value_q;
  assign commit_tag_out   = commit_tag_q;
  assign store_commit_out = store_commit_q;
  assign flush_out        = flush_q;
  assign flush_pc_out     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
`timescale 1ns/1ps
module tb_reorder_buffer;

  localparam logic [5:0] OP_JALR = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_BNE  = 6'd6;
  localparam logic [5:0] OP_BLT  = 6'd7;
  localparam logic [5:0] OP_SW   = 6'd18;
  localparam logic [5:0] OP_ADDI = 6'd19;
  localparam logic [5:0] OP_ADD  = 6'd27;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        dispatch_en_in = 1'b0;
  logic [5:0]  dispatch_opcode_in = '0;
  logic [4:0]  dispatch_dest_in = '0;
  logic [31:0] dispatch_pc_in = '0;
  logic        dispatch_taken_in = 1'b0;
  logic [3:0]  b_out;
  logic        full_out;
  logic [3:0]  rs_h_in = '0;
  logic [3:0]  rt_h_in = '0;
  logic        rs_ready_out, rt_ready_out;
  logic [31:0] rs_value_out, rt_value_out;
  logic        cdb_en_in = 1'b0;
  logic [3:0]  cdb_tag_in = '0;
  logic [31:0] cdb_value_in = '0;
  logic        cdb_taken_in = 1'b0;
  logic [31:0] cdb_target_in = '0;
  logic        commit_en_out;
  logic [4:0]  commit_reg_out;
  logic [31:0] commit_value_out;
  logic [3:0]  commit_tag_out;
  logic        store_commit_out;
  logic        lsb_store_done_in = 1'b0;
  logic        flush_out;
  logic [31:0] flush_pc_out;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatch_en_in(dispatch_en_in), .dispatch_opcode_in(dispatch_opcode_in),
    .dispatch_dest_in(dispatch_dest_in), .dispatch_pc_in(dispatch_pc_in),
    .dispatch_taken_in(dispatch_taken_in),
    .b_out(b_out), .full_out(full_out),
    .rs_h_in(rs_h_in), .rt_h_in(rt_h_in),
    .rs_ready_out(rs_ready_out), .rt_ready_out(rt_ready_out),
    .rs_value_out(rs_value_out), .rt_value_out(rt_value_out),
    .cdb_en_in(cdb_en_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .cdb_taken_in(cdb_taken_in), .cdb_target_in(cdb_target_in),
    .commit_en_out(commit_en_out), .commit_reg_out(commit_reg_out),
    .commit_value_out(commit_value_out), .commit_tag_out(commit_tag_out),
    .store_commit_out(store_commit_out), .lsb_store_done_in(lsb_store_done_in),
    .flush_out(flush_out), .flush_pc_out(flush_pc_out)
  );

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] val;
    logic [3:0]  tag;
  } commit_t;

  commit_t     exp_commit_q[$];
  logic [31:0] exp_flush_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [3:0]  exp_tag = 4'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [4:0] dest, input logic [31:0] pc,
                          input logic taken, input logic expect_write, input logic [31:0] val);
    check("b_out before dispatch", b_out, exp_tag);
    if (expect_write) exp_commit_q.push_back({dest, val, exp_tag});
    dispatch_en_in     = 1'b1;
    dispatch_opcode_in = op;
    dispatch_dest_in   = dest;
    dispatch_pc_in     = pc;
    dispatch_taken_in  = taken;
    tick();
    dispatch_en_in = 1'b0;
    exp_tag = (exp_tag == 4'd15) ? 4'd1 : exp_tag + 4'd1;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic taken,
                     input logic [31:0] target);
    cdb_en_in     = 1'b1;
    cdb_tag_in    = tag;
    cdb_value_in  = val;
    cdb_taken_in  = taken;
    cdb_target_in = target;
    tick();
    cdb_en_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_commit_q.size() + exp_flush_q.size()) != 0; i++) tick();
    tick();
    check(name, 64'(exp_commit_q.size() + exp_flush_q.size()), 64'd0);
  endtask

  task automatic wait_flush(input string name);
    for (int i = 0; i < 20 && !flush_out; i++) tick();
    check(name, flush_out, 1'b1);
    tick();
    exp_tag = 4'd1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    dispatch_en_in = 1'b0;
    cdb_en_in = 1'b0;
    lsb_store_done_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    exp_tag = 4'd1;
    exp_commit_q.delete();
    exp_flush_q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    commit_t e;
    if (rst_in) begin
      if (commit_en_out) begin
        if (exp_commit_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected commit: tag %0d reg %0d value 0x%0h, expected none",
                   commit_tag_out, commit_reg_out, commit_value_out);
        end else begin
          e = exp_commit_q.pop_front();
          check("commit reg", commit_reg_out, e.rg);
          check("commit value", commit_value_out, e.val);
          check("commit tag", commit_tag_out, e.tag);
        end
      end
      if (flush_out) begin
        if (exp_flush_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected flush: pc 0x%0h, expected none", flush_pc_out);
        end else begin
          check("flush pc", flush_pc_out, exp_flush_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #12;
    check("reset b_out", b_out, 4'd1);
    check("reset full", full_out, 1'b0);
    check("reset commit_en", commit_en_out, 1'b0);
    check("reset flush", flush_out, 1'b0);
    check("reset store_commit", store_commit_out, 1'b0);
    check("reset commit_value", commit_value_out, 32'd0);
    check("reset flush_pc", flush_pc_out, 32'd0);
    check("reset rs_ready", rs_ready_out, 1'b0);
    tick();
    rst_in = 1'b1;

    // Basic ALU commit, dest 0 retires silently
    dispatch(OP_ADDI, 5'd5, 32'h100, 1'b0, 1'b1, 32'd7);
    check("b_out after dispatch", b_out, 4'd2);
    cdb(4'd1, 32'd7, 1'b0, 32'd0);
    dispatch(OP_ADD, 5'd0, 32'h104, 1'b0, 1'b0, 32'd0);
    dispatch(OP_ADDI, 5'd13, 32'h108, 1'b0, 1'b1, 32'h33);
    cdb(4'd2, 32'h99, 1'b0, 32'd0);
    cdb(4'd3, 32'h33, 1'b0, 32'd0);
    drain("alu drain");

    // Operand query with CDB bypass
    do_reset();
    dispatch(OP_ADD, 5'd6, 32'h10, 1'b0, 1'b1, 32'h11);
    dispatch(OP_ADD, 5'd7, 32'h14, 1'b0, 1'b1, 32'h22);
    dispatch(OP_ADD, 5'd8, 32'h18, 1'b0, 1'b1, 32'hDEAD);
    rs_h_in = 4'd3;
    rt_h_in = 4'd0;
    #1;
    check("query before cdb ready", rs_ready_out, 1'b0);
    cdb_en_in = 1'b1; cdb_tag_in = 4'd3; cdb_value_in = 32'hDEAD;
    cdb_taken_in = 1'b0; cdb_target_in = '0;
    #1;
    check("bypass ready", rs_ready_out, 1'b1);
    check("bypass value", rs_value_out, 32'hDEAD);
    check("tag0 not ready", rt_ready_out, 1'b0);
    tick();
    cdb_en_in = 1'b0;
    rt_h_in = 4'd2;
    #1;
    check("stored ready", rs_ready_out, 1'b1);
    check("stored value", rs_value_out, 32'hDEAD);
    check("unready entry", rt_ready_out, 1'b0);
    check("no out-of-order commit", commit_en_out, 1'b0);
    rs_h_in = '0;
    rt_h_in = '0;
    cdb(4'd1, 32'h11, 1'b0, 32'd0);
    cdb(4'd2, 32'h22, 1'b0, 32'd0);
    drain("query drain");

    // Fill to full, blocked 16th dispatch, tag wrap
    do_reset();
    for (int i = 1; i <= 15; i++)
      dispatch(OP_ADDI, 5'd9, 32'h1000 + 32'(4 * i), 1'b0, 1'b1, 32'h100 + 32'(i));
    check("full after 15", full_out, 1'b1);
    check("b_out wrapped", b_out, 4'd1);
    dispatch_en_in = 1'b1; dispatch_opcode_in = OP_ADDI; dispatch_dest_in = 5'd31;
    dispatch_pc_in = 32'hBAD;
    tick();
    dispatch_en_in = 1'b0;
    check("16th ignored b_out", b_out, 4'd1);
    check("16th ignored full", full_out, 1'b1);
    cdb(4'd1, 32'h101, 1'b0, 32'd0);
    tick();
    check("full clears after retire", full_out, 1'b0);
    dispatch(OP_ADDI, 5'd9, 32'h2000, 1'b0, 1'b1, 32'h1FF);
    for (int t = 2; t <= 15; t++) cdb(4'(t), 32'h100 + 32'(t), 1'b0, 32'd0);
    cdb(4'd1, 32'h1FF, 1'b0, 32'd0);
    drain("full drain");

    // Branches and JALR
    do_reset();
    dispatch(OP_BNE, 5'd0, 32'h180, 1'b1, 1'b0, 32'd0);
    cdb(4'd1, 32'd0, 1'b1, 32'h300);
    tick(); tick(); tick();
    dispatch(OP_BEQ, 5'd0, 32'h200, 1'b0, 1'b0, 32'd0);
    dispatch(OP_ADD, 5'd10, 32'h204, 1'b0, 1'b0, 32'd0);
    dispatch(OP_ADD, 5'd11, 32'h208, 1'b0, 1'b0, 32'd0);
    cdb(4'd3, 32'd1, 1'b0, 32'd0);
    cdb(4'd4, 32'd2, 1'b0, 32'd0);
    exp_flush_q.push_back(32'h240);
    cdb(4'd2, 32'd0, 1'b1, 32'h240);
    wait_flush("beq flush seen");
    check("b_out after flush", b_out, 4'd1);
    check("full after flush", full_out, 1'b0);
    tick(); tick(); tick();

    dispatch(OP_BLT, 5'd0, 32'h600, 1'b1, 1'b0, 32'd0);
    exp_flush_q.push_back(32'h604);
    cdb(4'd1, 32'd0, 1'b0, 32'h640);
    wait_flush("blt flush seen");

    dispatch(OP_JALR, 5'd1, 32'h400, 1'b0, 1'b1, 32'h404);
    exp_flush_q.push_back(32'h500);
    cdb(4'd1, 32'h404, 1'b0, 32'h500);
    wait_flush("jalr flush seen");
    check("b_out after jalr", b_out, 4'd1);
    drain("branch drain");

    // Store handshake with delayed done
    do_reset();
    dispatch(OP_SW, 5'd0, 32'h700, 1'b0, 1'b0, 32'd0);
    dispatch(OP_ADD, 5'd12, 32'h704, 1'b0, 1'b1, 32'h55);
    cdb(4'd2, 32'h55, 1'b0, 32'd0);
    cdb(4'd1, 32'h0, 1'b0, 32'd0);
    for (int i = 0; i < 10 && !store_commit_out; i++) tick();
    check("store_commit cycle 1", store_commit_out, 1'b1);
    check("no commit in wait 1", commit_en_out, 1'b0);
    tick();
    check("store_commit cycle 2", store_commit_out, 1'b1);
    check("no commit in wait 2", commit_en_out, 1'b0);
    tick();
    check("store_commit cycle 3", store_commit_out, 1'b1);
    lsb_store_done_in = 1'b1;
    tick();
    lsb_store_done_in = 1'b0;
    check("store_commit drops", store_commit_out, 1'b0);
    check("no commit on done edge", commit_en_out, 1'b0);
    tick();
    check("add commits after store", commit_en_out, 1'b1);
    drain("store drain");

    // Asynchronous reset during STORE_WAIT
    do_reset();
    dispatch(OP_SW, 5'd0, 32'h800, 1'b0, 1'b0, 32'd0);
    cdb(4'd1, 32'h0, 1'b0, 32'd0);
    for (int i = 0; i < 10 && !store_commit_out; i++) tick();
    check("store_commit before reset", store_commit_out, 1'b1);
    #3;
    rst_in = 1'b0;
    #1;
    check("async reset store_commit", store_commit_out, 1'b0);
    check("async reset b_out", b_out, 4'd1);
    check("async reset full", full_out, 1'b0);
    check("async reset commit_en", commit_en_out, 1'b0);
    check("async reset flush", flush_out, 1'b0);
    tick();
    rst_in = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer for the Tomasulo core. It is the receiving end of the dispatch interface: it allocates an entry per dispatched instruction, returns the allocated tag, and answers the dispatcher's two operand-forwarding queries. It captures CDB results, retires in order to the regfile, sequences store commits with the LSB, and flushes the pipeline on branch mispredict or JALR.

Parameters:
ROB_WIDTH, 4, tag width; tag 0 means "no producer", so the usable entries are 1..2^ROB_WIDTH-1 (15 entries)
ID_WIDTH, 32, data width
ADDR_WIDTH, 32, PC width
REG_WIDTH, 5, architectural register index width
OP_WIDTH, 6, opcode width (InstTypeWidth)

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; 0 freezes all state
dispatch_en_in  in  1  allocate an entry this cycle
dispatch_opcode_in  in  OP_WIDTH  instruction type
dispatch_dest_in  in  REG_WIDTH  destination register (0 = none)
dispatch_pc_in  in  ADDR_WIDTH  instruction PC
dispatch_taken_in  in  1  predicted taken
b_out  out  ROB_WIDTH  tag the next dispatch receives (tail)
full_out  out  1  no free entry
rs_h_in, rt_h_in  in  ROB_WIDTH  operand query tags
rs_ready_out, rt_ready_out  out  1  queried entry has a value
rs_value_out, rt_value_out  out  ID_WIDTH  queried value
cdb_en_in  in  1  result broadcast
cdb_tag_in  in  ROB_WIDTH  producing entry
cdb_value_in  in  ID_WIDTH  result
cdb_taken_in  in  1  actual branch outcome
cdb_target_in  in  ADDR_WIDTH  actual target (branch/JALR)
commit_en_out  out  1  regfile write strobe
commit_reg_out  out  REG_WIDTH  register written
commit_value_out  out  ID_WIDTH  value written
commit_tag_out  out  ROB_WIDTH  retiring tag (regfile clears busy only on a tag match)
store_commit_out  out  1  permit the LSB to perform the head store
lsb_store_done_in  in  1  store completed
flush_out  out  1  squash everything younger
flush_pc_out  out  ADDR_WIDTH  redirect PC

Behaviour:
- Reset (rst_in=0, asynchronous): head=tail=1, count=0, all valid/ready bits cleared, FSM=RUN.
- Reset values of outputs: all strobes 0, b_out=1, full_out=0, data outputs 0.
- Tags advance 1..2^ROB_WIDTH-1 and wrap to 1, never to 0.
- full_out = (count == 2^ROB_WIDTH-1).
- Dispatch handling:
  - A dispatch while full is ignored.
  - A dispatch writes the entry at tail with ready=0; tail and count increment on the next clock edge.
- Queries are combinational:
  - ready/value come from the entry.
  - If cdb_en_in and cdb_tag_in equals the queried tag in the same cycle, return ready=1 and the CDB value (bypass).
  - Tag 0 returns ready=0.
- CDB: sets ready, value, taken and target of entry cdb_tag_in on the clock edge. A CDB write to an invalid entry is ignored.
- Commit, one per cycle, when head is valid and ready. Outputs are registered and pulse for 1 cycle.
  - ALU/load/JAL: commit_en_out=1 with dest/value/tag; dest 0 gives commit_en_out=0 but the entry still retires.
  - Branch (BEQ..BGEU): no regfile write. If actual taken != predicted, flush_out=1 with flush_pc_out = taken ? target : pc+4.
  - JALR: writes the link value and always flushes with flush_pc_out = target.
  - Store (SB/SH/SW): FSM RUN -> STORE_WAIT, asserting store_commit_out (held high) until lsb_store_done_in=1. The entry then retires and the FSM returns to RUN. No other commit happens during STORE_WAIT.
- Flush: on the edge after the flushing commit, all entries are invalidated, head=tail=1, count=0, and the FSM goes to RUN. Dispatch and CDB in the flush cycle are discarded.
- Simultaneous dispatch and commit: count is unchanged. At full, commit frees a slot but dispatch stays blocked that cycle (full_out is evaluated on current count).
- CDB and commit of the same entry in one cycle: the commit waits until the next cycle.
- rdy_in=0: no state changes; commit strobes are held 0.

Test Plan:
- Reset, dispatch ADDI x5 (pc 0x100) -> b_out goes 1 then 2; CDB tag1 value 7 -> next cycle commit_en_out=1, reg 5, value 7, tag 1.
- Dispatch 15 instructions -> full_out=1; a 16th dispatch is ignored; the tag after 15 wraps to 1 once head retires.
- Query rs_h=3 while CDB broadcasts tag 3 value 0xDEAD -> rs_ready_out=1, rs_value_out=0xDEAD in the same cycle.
- BEQ at pc 0x200 predicted not-taken, CDB taken=1 target 0x240, plus 2 younger entries -> flush_out=1, flush_pc_out=0x240; next cycle b_out=1, full_out=0, younger entries never commit.
- SW at head ready, lsb_store_done_in delayed 3 cycles -> store_commit_out high 3 cycles, a ready ADD behind it commits the cycle after done.
- Assert rst_in=0 mid-STORE_WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.
